// File: rtl/lsu_bus_if.sv
// Data-bus side of the load/store unit: valid/ready request channel plus read return.
interface lsu_bus_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_bus.sv
// Load/store unit: turns the datapath memory port into a gnt/rvalid bus transaction,
// stalling the core until the access completes, times out, or is found misaligned.
module lsu_bus #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    lsu_bus_if.master   bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_rdata, r_cnt;
    logic [3:0]  r_be;
    logic        r_we;
    logic [2:0]  r_f3;

    logic        w_acc, w_busy, w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_sh, w_ext;

    assign w_acc    = mem_re | mem_we;
    assign misalign = w_acc && ((funct3[1:0] == 2'b01 && addr[0]) ||
                                (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00));
    assign stall    = w_acc && !misalign && (r_state != DONE);
    assign rdata    = misalign ? 32'd0 : r_rdata;

    assign w_busy = (r_state == REQ) || (r_state == RESP);
    assign w_tmo  = w_busy && (TIMEOUT != 0) && (r_cnt == TIMEOUT);

    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = {r_addr[31:2], 2'b00};
    assign bus.bus_be    = r_be;
    assign bus.bus_wdata = r_wdata;

    // Unknown sizes (funct3[1:0]=11) fall into the word case.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Halves are aligned, so shifting by the byte offset lands either size in the low bits.
    assign w_sh = bus.bus_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ext = w_sh;
        case (r_f3[1:0])
            2'b00:   w_ext = {{24{w_sh[7]  & ~r_f3[2]}}, w_sh[7:0]};
            2'b01:   w_ext = {{16{w_sh[15] & ~r_f3[2]}}, w_sh[15:0]};
            default: w_ext = bus.bus_rdata;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        bus.bus_req = 1'b0;
        bus_err     = 1'b0;
        case (r_state)
            IDLE: if (w_acc && !misalign) w_next = REQ;
            REQ: begin
                if (w_tmo) begin
                    bus_err = 1'b1;
                    w_next  = DONE;
                end else begin
                    bus.bus_req = 1'b1;
                    if (bus.bus_gnt) w_next = r_we ? DONE : RESP;
                end
            end
            RESP: begin
                if (w_tmo) begin
                    bus_err = 1'b1;
                    w_next  = DONE;
                end else if (bus.bus_rvalid) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_f3    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == REQ) begin
                r_addr  <= addr;
                r_wdata <= w_wdata;
                r_be    <= w_be;
                r_we    <= mem_we;
                r_f3    <= funct3;
            end
            if (w_tmo)
                r_rdata <= '0;
            else if (r_state == RESP && bus.bus_rvalid)
                r_rdata <= w_ext;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_busy)
                r_cnt <= r_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_lsu_bus.sv
// Scoreboarded bench for lsu_bus: directed transactions push expected bus requests and
// DONE-cycle read data; a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu_bus;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_re, mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misalign, bus_err;

    lsu_bus_if bus_i();

    lsu_bus #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .mem_re(mem_re), .mem_we(mem_we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .misalign(misalign), .bus_err(bus_err), .bus(bus_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } bus_exp_t;

    bus_exp_t    bq[$];
    logic [31:0] dq[$];
    logic [31:0] last_rd;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: bus handshakes and DONE cycles are checked against the queues.
    always @(negedge clk) begin
        bus_exp_t e;
        logic [31:0] d;
        if (!reset && bus_i.bus_req && bus_i.bus_gnt) begin
            if (bq.size() == 0) begin
                checks++; errors++;
                $display("FAIL bus_unexpected: got request addr %h expected none", bus_i.bus_addr);
            end else begin
                e = bq.pop_front();
                chk("bus_addr",  bus_i.bus_addr,  e.addr);
                chk("bus_be",    {28'd0, bus_i.bus_be}, {28'd0, e.be});
                chk("bus_wdata", bus_i.bus_wdata, e.wd);
                chk("bus_we",    {31'd0, bus_i.bus_we}, {31'd0, e.we});
            end
        end
        if (!reset && (mem_re || mem_we) && !stall && !misalign) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected: got rdata %h expected no completion", rdata);
            end else begin
                d = dq.pop_front();
                chk("done_rdata", rdata, d);
            end
        end
    end

    // gw: REQ cycles without gnt (-1 = never); rw: RESP cycles without rvalid.
    task automatic op(input string nm, input logic re, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int gw, input int rw,
                      input logic [31:0] word, input logic [31:0] exp_rd, input logic [3:0] ebe,
                      input logic [31:0] ewd, input int ereq, input int estall, input int eerr);
        int req_c = 0, st_c = 0, err_c = 0, rc = 0, ph = 0;
        bit done = 1'b0;
        @(posedge clk); #1;
        mem_re = re; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        if (gw >= 0) bq.push_back('{{a[31:2], 2'b00}, ebe, ewd, we});
        dq.push_back(exp_rd);
        if (!we) last_rd = exp_rd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall) st_c++;
            if (bus_i.bus_req) req_c++;
            if (bus_err) err_c++;
            bus_i.bus_gnt = 1'b0; bus_i.bus_rvalid = 1'b0;
            if (!stall) begin
                done = 1'b1;
            end else if (ph == 0) begin
                // Stray rvalid before the grant must be ignored.
                bus_i.bus_rvalid = 1'b1; bus_i.bus_rdata = 32'hBAD0BAD0;
                if (bus_i.bus_req && gw >= 0 && req_c > gw) begin
                    bus_i.bus_gnt = 1'b1; ph = 1;
                end
            end else if (!we) begin
                if (rc >= rw) begin
                    bus_i.bus_rvalid = 1'b1; bus_i.bus_rdata = word;
                end
                rc++;
            end
            if (!done) begin @(posedge clk); #1; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no DONE expected DONE within 40 cycles", nm);
        end
        chk({nm, "_req_cycles"},   req_c, ereq);
        chk({nm, "_stall_cycles"}, st_c,  estall);
        chk({nm, "_err_cycles"},   err_c, eerr);
        bus_i.bus_gnt = 1'b0; bus_i.bus_rvalid = 1'b0;
        @(posedge clk); #1;
        mem_re = 1'b0; mem_we = 1'b0;
    endtask

    task automatic mis(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a);
        @(posedge clk); #1;
        mem_re = !we; mem_we = we; funct3 = f3; addr = a; wdata = 32'h11223344;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk({nm, "_misalign"}, {31'd0, misalign}, 32'd1);
            chk({nm, "_stall"},    {31'd0, stall},    32'd0);
            chk({nm, "_bus_req"},  {31'd0, bus_i.bus_req}, 32'd0);
            chk({nm, "_rdata"},    rdata, 32'd0);
            @(posedge clk); #1;
        end
        mem_re = 1'b0; mem_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mem_re = 1'b0; mem_we = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; last_rd = '0;
        bus_i.bus_gnt = 1'b0; bus_i.bus_rvalid = 1'b0; bus_i.bus_rdata = '0;
        #12;
        chk("rst_rdata",     rdata, 32'd0);
        chk("rst_stall",     {31'd0, stall}, 32'd0);
        chk("rst_bus_req",   {31'd0, bus_i.bus_req}, 32'd0);
        chk("rst_bus_addr",  bus_i.bus_addr, 32'd0);
        chk("rst_bus_be",    {28'd0, bus_i.bus_be}, 32'd0);
        chk("rst_bus_wdata", bus_i.bus_wdata, 32'd0);
        chk("rst_bus_err",   {31'd0, bus_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        op("sw",   0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 0, 0, last_rd, 4'b1111, 32'hDEADBEEF, 3, 4, 0);
        op("sb",   0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, last_rd, 4'b1000, 32'hA5A5A5A5, 1, 2, 0);
        op("sh",   0, 1, 3'b001, 32'h202, 32'h1234BEEF, 1, 0, 0, last_rd, 4'b1100, 32'hBEEFBEEF, 2, 3, 0);
        op("lb",   1, 0, 3'b000, 32'h202, 0, 0, 0, 32'h80F17F00, 32'hFFFFFFF1, 4'b0100, 0, 1, 3, 0);
        op("lbu",  1, 0, 3'b100, 32'h202, 0, 1, 2, 32'h80F17F00, 32'h000000F1, 4'b0100, 0, 2, 6, 0);
        op("lh",   1, 0, 3'b001, 32'h202, 0, 0, 1, 32'h80F17F00, 32'hFFFF80F1, 4'b1100, 0, 1, 4, 0);
        op("lhu",  1, 0, 3'b101, 32'h202, 0, 0, 0, 32'h80F17F00, 32'h000080F1, 4'b1100, 0, 1, 3, 0);
        op("lb1",  1, 0, 3'b000, 32'h201, 0, 0, 0, 32'h80F17F00, 32'h0000007F, 4'b0010, 0, 1, 3, 0);
        op("lh0",  1, 0, 3'b001, 32'h200, 0, 0, 0, 32'h80F17F00, 32'h00007F00, 4'b0011, 0, 1, 3, 0);
        op("lw",   1, 0, 3'b010, 32'h204, 0, 3, 0, 32'h89ABCDEF, 32'h89ABCDEF, 4'b1111, 0, 4, 6, 0);
        op("rwst", 1, 1, 3'b010, 32'h208, 32'h00000055, 0, 0, 0, last_rd, 4'b1111, 32'h00000055, 1, 2, 0);
        op("f3u",  1, 0, 3'b011, 32'h20C, 0, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 0, 1, 3, 0);

        mis("mis_lw", 1'b0, 3'b010, 32'h106);
        mis("mis_sh", 1'b1, 3'b001, 32'h101);

        op("tmo",  1, 0, 3'b010, 32'h400, 0, -1, 0, 0, 32'h00000000, 4'b1111, 0, 4, 6, 1);

        // Reset while the request is pending: bus_req must fall without a clock.
        @(posedge clk); #1;
        mem_re = 1'b1; funct3 = 3'b010; addr = 32'h500;
        @(posedge clk); #1;
        chk("rstreq_req_before", {31'd0, bus_i.bus_req}, 32'd1);
        reset = 1'b1; mem_re = 1'b0;
        #1;
        chk("rstreq_req_after", {31'd0, bus_i.bus_req}, 32'd0);
        chk("rstreq_bus_err",   {31'd0, bus_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset while waiting for read data.
        @(posedge clk); #1;
        mem_re = 1'b1; funct3 = 3'b010; addr = 32'h504;
        bq.push_back('{32'h504, 4'b1111, 32'h0, 1'b0});
        @(posedge clk); #1;
        bus_i.bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_i.bus_gnt = 1'b0;
        #1;
        chk("rstresp_req",   {31'd0, bus_i.bus_req}, 32'd0);
        chk("rstresp_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1; mem_re = 1'b0;
        #1;
        chk("rstresp_bus_err",  {31'd0, bus_err}, 32'd0);
        chk("rstresp_rdata",    rdata, 32'd0);
        chk("rstresp_bus_addr", bus_i.bus_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_rd = '0;

        op("lw_rst", 1, 0, 3'b010, 32'h300, 0, 0, 0, 32'h12345678, 32'h12345678, 4'b1111, 0, 1, 3, 0);

        @(posedge clk); #1;
        chk("bq_empty", bq.size(), 32'd0);
        chk("dq_empty", dq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
